// File: rtl/debug_host_ctrl.sv
// Host-side driver for the core's single-step debug port: halt/step/resume control and
// valid/ready register dumps. Define DEBUG_HOST_CHECKSUM_EN to append an XOR checksum word.
module debug_host_ctrl #(
  parameter int   NUM_WORDS  = 64,
  parameter int   STEP_HIGH  = 2,
  parameter int   STEP_LOW   = 2,
  parameter int   SETTLE     = 1,
  parameter logic RESET_HALT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_cnt,
  output logic        debug_en,
  output logic        debug_step,
  output logic [6:0]  debug_addr,
  input  logic [31:0] debug_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [6:0]  out_addr,
  output logic        out_last,
  output logic        busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_STEP_HI = 3'd1;
  localparam logic [2:0] S_STEP_LO = 3'd2;
  localparam logic [2:0] S_ADDR    = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;

  localparam logic [1:0] OP_HALT   = 2'd0;
  localparam logic [1:0] OP_STEP   = 2'd1;
  localparam logic [1:0] OP_DUMP   = 2'd2;
  localparam logic [1:0] OP_RESUME = 2'd3;

  localparam int              PH_W      = 16;
  localparam logic [PH_W-1:0] HI_END    = PH_W'(STEP_HIGH - 1);
  localparam logic [PH_W-1:0] LO_END    = PH_W'(STEP_LOW - 1);
  localparam logic [PH_W-1:0] SET_END   = PH_W'(SETTLE - 1);
  localparam logic [6:0]      LAST_ADDR = 7'(NUM_WORDS - 1);
`ifdef DEBUG_HOST_CHECKSUM_EN
  localparam logic [6:0]      CSUM_ADDR = 7'h7F;
`endif

  logic [2:0]      r_state;
  logic [PH_W-1:0] r_phase;
  logic [7:0]      r_remain;
  logic            r_en;
  logic            r_step;
  logic [6:0]      r_addr;
  logic            r_out_valid;
  logic [31:0]     r_out_data;
  logic [6:0]      r_out_addr;
  logic            r_out_last;
  logic            r_busy;
  logic            r_cmd_ready;
`ifdef DEBUG_HOST_CHECKSUM_EN
  logic [31:0]     r_csum;
`endif

  logic [2:0] w_nxt;
  logic       w_acc;
  logic       w_xfer;
  logic       w_hi_end;
  logic       w_lo_end;
  logic       w_set_end;

  always_comb begin
    w_acc     = cmd_valid & r_cmd_ready;
    w_xfer    = r_out_valid & out_ready;
    w_hi_end  = (r_phase == HI_END);
    w_lo_end  = (r_phase == LO_END);
    w_set_end = (r_phase == SET_END);
    w_nxt     = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (cmd_op == OP_STEP && cmd_cnt != 8'd0) w_nxt = S_STEP_HI;
          else if (cmd_op == OP_DUMP)               w_nxt = S_ADDR;
        end
      end
      S_STEP_HI: if (w_hi_end) w_nxt = S_STEP_LO;
      S_STEP_LO: if (w_lo_end) w_nxt = (r_remain == 8'd1) ? S_IDLE : S_STEP_HI;
      S_ADDR:    w_nxt = S_WAIT;
      S_WAIT:    if (w_set_end) w_nxt = S_OUT;
      S_OUT: begin
        if (w_xfer) begin
          if (r_out_last) w_nxt = S_IDLE;
`ifdef DEBUG_HOST_CHECKSUM_EN
          // Stay in OUT to present the checksum word after the final data word.
          else if (r_addr == LAST_ADDR) w_nxt = S_OUT;
`endif
          else w_nxt = S_ADDR;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_remain    <= 8'd0;
      r_en        <= RESET_HALT;
      r_step      <= 1'b0;
      r_addr      <= 7'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= 32'd0;
      r_out_addr  <= 7'd0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
`ifdef DEBUG_HOST_CHECKSUM_EN
      r_csum      <= 32'd0;
`endif
    end else begin
      // Status outputs follow the next state so they stay registered yet cycle-exact.
      r_state     <= w_nxt;
      r_busy      <= (w_nxt != S_IDLE);
      r_cmd_ready <= (w_nxt == S_IDLE);
      r_step      <= (w_nxt == S_STEP_HI);

      if (w_nxt != r_state)
        r_phase <= '0;
      else if (r_state == S_STEP_HI || r_state == S_STEP_LO || r_state == S_WAIT)
        r_phase <= r_phase + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            case (cmd_op)
              OP_HALT:   r_en <= 1'b1;
              OP_RESUME: r_en <= 1'b0;
              OP_STEP: begin
                r_en     <= 1'b1;
                r_remain <= cmd_cnt;
              end
              OP_DUMP: begin
                r_addr <= 7'd0;
`ifdef DEBUG_HOST_CHECKSUM_EN
                r_csum <= 32'd0;
`endif
              end
              default: ;
            endcase
          end
        end
        S_STEP_LO: if (w_lo_end) r_remain <= r_remain - 8'd1;
        S_WAIT: begin
          if (w_set_end) begin
            r_out_valid <= 1'b1;
            r_out_data  <= debug_data;
            r_out_addr  <= r_addr;
`ifdef DEBUG_HOST_CHECKSUM_EN
            r_out_last  <= 1'b0;
            r_csum      <= r_csum ^ debug_data;
`else
            r_out_last  <= (r_addr == LAST_ADDR);
`endif
          end
        end
        S_OUT: begin
          if (w_xfer) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_out_last <= 1'b0;
            end
`ifdef DEBUG_HOST_CHECKSUM_EN
            else if (r_addr == LAST_ADDR) begin
              r_out_valid <= 1'b1;
              r_out_addr  <= CSUM_ADDR;
              r_out_data  <= r_csum;
              r_out_last  <= 1'b1;
            end
`endif
            else begin
              r_addr <= r_addr + 7'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign busy       = r_busy;
  assign debug_en   = r_en;
  assign debug_step = r_step;
  assign debug_addr = r_addr;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_addr   = r_out_addr;
  assign out_last   = r_out_last;

endmodule

// File: tb/tb_debug_host_ctrl.sv
// Randomized bench for debug_host_ctrl against a command-level model of step pulses,
// debug_en tracking and the expected dump word sequence.
module tb_debug_host_ctrl;

  localparam int   NW = 64;
  localparam int   SH = 2;
  localparam int   SL = 2;
  localparam int   ST = 1;
  localparam logic RH = 1'b1;
`ifdef DEBUG_HOST_CHECKSUM_EN
  localparam int   CS = 1;
`else
  localparam int   CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_cnt = 8'd0;
  logic        debug_en;
  logic        debug_step;
  logic [6:0]  debug_addr;
  logic [31:0] debug_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [6:0]  out_addr;
  logic        out_last;
  logic        busy;

  logic [31:0] mem [0:127];
  assign debug_data = mem[debug_addr];

  debug_host_ctrl #(
    .NUM_WORDS(NW), .STEP_HIGH(SH), .STEP_LOW(SL), .SETTLE(ST), .RESET_HALT(RH)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_cnt(cmd_cnt),
    .debug_en(debug_en), .debug_step(debug_step), .debug_addr(debug_addr),
    .debug_data(debug_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  logic model_en;

  logic [6:0]  e_addr [0:128];
  logic [31:0] e_data [0:128];
  logic        e_last [0:128];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] cnt);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check_eq("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (op == 2'd0 || op == 2'd1) model_en = 1'b1;
    else if (op == 2'd3)          model_en = 1'b0;
  endtask

  // Pulse train: cnt periods of SH high then SL low, busy for the whole train.
  task automatic run_step(input int cnt, input bit noise);
    int total;
    send_cmd(2'd1, 8'(cnt));
    total = cnt * (SH + SL);
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      cmd_op    = 2'd3;
      cmd_valid = noise && (k != total - 1);
      check_eq("step_busy",  {31'd0, busy},       32'd1);
      check_eq("step_ready", {31'd0, cmd_ready},  32'd0);
      check_eq("step_pulse", {31'd0, debug_step}, {31'd0, ((k % (SH + SL)) < SH)});
      check_eq("step_en",    {31'd0, debug_en},   32'd1);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("step_done_busy",  {31'd0, busy},       32'd0);
    check_eq("step_done_ready", {31'd0, cmd_ready},  32'd1);
    check_eq("step_done_pulse", {31'd0, debug_step}, 32'd0);
    check_eq("step_done_en",    {31'd0, debug_en},   {31'd0, model_en});
  endtask

  // mode 0: sink always ready, 1: one cycle on / three off, 2: random.
  task automatic run_dump(input int mode);
    int          nexp, idx, cyc, busy_cnt;
    logic [31:0] x;
    logic        rdy, prev_stall;
    logic [31:0] p_data;
    logic [6:0]  p_addr, p_daddr;
    logic        p_last;
    x = 32'd0;
    for (int a = 0; a < NW; a++) begin
      e_addr[a] = 7'(a);
      e_data[a] = mem[a];
      e_last[a] = (CS == 0) && (a == NW - 1);
      x = x ^ mem[a];
    end
    nexp = NW;
    if (CS != 0) begin
      e_addr[NW] = 7'h7F;
      e_data[NW] = x;
      e_last[NW] = 1'b1;
      nexp = NW + 1;
    end
    send_cmd(2'd2, 8'd0);
    idx = 0; cyc = 0; busy_cnt = 0; prev_stall = 1'b0;
    p_data = '0; p_addr = '0; p_daddr = '0; p_last = 1'b0;
    while (idx < nexp && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      check_eq("addr_range", {31'd0, (debug_addr <= 7'(NW - 1))}, 32'd1);
      if (prev_stall) begin
        check_eq("stall_valid", {31'd0, out_valid},  32'd1);
        check_eq("stall_data",  out_data,            p_data);
        check_eq("stall_addr",  {25'd0, out_addr},   {25'd0, p_addr});
        check_eq("stall_last",  {31'd0, out_last},   {31'd0, p_last});
        check_eq("stall_daddr", {25'd0, debug_addr}, {25'd0, p_daddr});
      end
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = ((cyc % 4) == 1);
      else                rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      if (out_valid && rdy) begin
        check_eq("word_addr", {25'd0, out_addr}, {25'd0, e_addr[idx]});
        check_eq("word_data", out_data,          e_data[idx]);
        check_eq("word_last", {31'd0, out_last}, {31'd0, e_last[idx]});
        idx++;
      end
      prev_stall = out_valid && !rdy;
      p_data = out_data; p_addr = out_addr; p_last = out_last; p_daddr = debug_addr;
    end
    check_eq("dump_words", idx, nexp);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("dump_done_busy",  {31'd0, busy},      32'd0);
    check_eq("dump_done_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("dump_done_valid", {31'd0, out_valid}, 32'd0);
    check_eq("dump_done_en",    {31'd0, debug_en},  {31'd0, model_en});
    if (mode == 0) check_eq("dump_cycles", busy_cnt, NW * (2 + ST) + CS);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_en"},    {31'd0, debug_en},   {31'd0, RH});
    check_eq({tag, "_step"},  {31'd0, debug_step}, 32'd0);
    check_eq({tag, "_busy"},  {31'd0, busy},       32'd0);
    check_eq({tag, "_ready"}, {31'd0, cmd_ready},  32'd1);
    check_eq({tag, "_valid"}, {31'd0, out_valid},  32'd0);
    check_eq({tag, "_last"},  {31'd0, out_last},   32'd0);
    check_eq({tag, "_data"},  out_data,            32'd0);
    check_eq({tag, "_oaddr"}, {25'd0, out_addr},   32'd0);
    check_eq({tag, "_daddr"}, {25'd0, debug_addr}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int op;
    model_en = RH;
    for (int i = 0; i < 128; i++) mem[i] = 32'(i);
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Basic stepping, including a zero count and a full-scale count.
    run_step(3, 1'b0);
    run_step(0, 1'b0);
    check_eq("cnt0_ready_hold", {31'd0, cmd_ready}, 32'd1);
    send_cmd(2'd3, 8'd0);
    @(negedge clk);
    check_eq("resume_en", {31'd0, debug_en}, 32'd0);
    run_step(0, 1'b0);
    run_step(2, 1'b1);
    run_step(255, 1'b0);

    // Address-echo stub, free-flowing then stalled sink.
    run_dump(0);
    run_dump(1);

    // Reset during the second step pulse.
    send_cmd(2'd1, 8'd3);
    repeat (5) @(negedge clk);
    check_eq("rst_pre_step", {31'd0, debug_step}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_step",  {31'd0, debug_step}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy},       32'd0);
    check_eq("rst_ready", {31'd0, cmd_ready},  32'd1);
    check_eq("rst_en",    {31'd0, debug_en},   {31'd0, RH});
    model_en = RH;
    @(negedge clk);
    rst = 1'b0;
    run_step(2, 1'b0);

    // Reset with a word pending on the output.
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    send_cmd(2'd3, 8'd0);
    send_cmd(2'd2, 8'd0);
    out_ready = 1'b0;
    for (int w = 0; w < 20 && !out_valid; w++) @(negedge clk);
    check_eq("pend_valid_seen", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_state("rst_dump");
    model_en = RH;
    @(negedge clk);
    rst = 1'b0;

    // Random command mix.
    for (int n = 0; n < 12; n++) begin
      op = $urandom_range(0, 3);
      if (op == 1) begin
        run_step($urandom_range(0, 5), 1'($urandom_range(0, 1)));
      end else if (op == 2) begin
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        run_dump($urandom_range(0, 2));
      end else begin
        send_cmd(2'(op), 8'($urandom));
        @(negedge clk);
        check_eq("ctl_en",   {31'd0, debug_en}, {31'd0, model_en});
        check_eq("ctl_busy", {31'd0, busy},     32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
